uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  Serial receive front-end of the UART: synchronises R_X, detects start bits with 16x oversampling,
//  and deserialises 8N1 frames (LSB first) into a byte with error flags.
//  Sits between the R_X pin and the UART register block; that block latches rx_data and pulses rx_ack
//  when software reads the data register.
// PARAMETERS
//  DIV_W       8   width of baud_div (oversample tick divisor)
//  PARITY_ODD  0   parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd
// PORTS
//  clk         in   1      system clock (20 MHz nominal)
//  reset       in   1      asynchronous, active-low reset
//  rx_in       in   1      raw serial line (R_X); idles high
//  baud_div    in   DIV_W  16x tick period minus 1 (tick every baud_div+1 clocks)
//  rx_ack      in   1      consumer has taken rx_data; clears rx_valid/overrun
//  rx_data     out  8      last received byte
//  rx_valid    out  1      byte available; held high until rx_ack
//  frame_err   out  1      stop bit of the byte in rx_data sampled 0
//  parity_err  out  1      parity mismatch for the byte in rx_data (tied 0 without UART_RX_PARITY_EN)
//  overrun     out  1      sticky: a frame completed while rx_valid was high; cleared by rx_ack
// BEHAVIOUR
//  - Reset (reset==0, async): all outputs 0, FSM in IDLE, synchroniser flops preset to 1, tick counter 0.
//  - rx_in passes a 2-FF synchroniser (preset 1); all decisions use the synchronised bit rx_s.
//  - Tick gen: free-running counter 0..baud_div; tick on the clock where count==baud_div, then reloads to 0.
//    baud_div==0 -> tick every clock. A baud_div change takes effect at the next reload; the frame in flight is undefined.
//  - FSM advances only on ticks; scnt (4-bit) counts ticks inside each bit; bcnt (3-bit) counts data bits.
//    IDLE:  rx_s==0 on a tick -> START, scnt=0.
//    START: on scnt==7 (mid-bit) sample; rx_s==1 -> IDLE (glitch, no output); rx_s==0 -> DATA, scnt=0, bcnt=0.
//    DATA:  on scnt==15 shift rx_s into shreg MSB (LSB-first line order); after bcnt==7 -> PARITY if enabled, else STOP.
//    PARITY: on scnt==15 sample the parity bit -> STOP.
//    STOP:  on scnt==15 sample the stop bit -> deliver; rx_s==1 -> IDLE, rx_s==0 -> BREAK.
//    BREAK: stay until rx_s==1 on a tick -> IDLE (no new start is armed while the line is held low).
//  - Deliver (one clock after the stop-sample tick):
//    if rx_valid==0 or rx_ack is high that same clock -> rx_data<=shreg, frame_err/parity_err<=flags, rx_valid<=1;
//    otherwise -> rx_data and flags keep the old byte, new byte discarded, overrun<=1.
//  - rx_ack while rx_valid==1 with no simultaneous deliver -> rx_valid<=0, overrun<=0; rx_data and flags hold.
//    rx_ack while rx_valid==0 is ignored.
//  - Latency: rx_valid rises 1 clk after the mid-stop-bit tick (~9.5 bit times after the start edge, +<=1 tick jitter).
//  - Reset mid-frame aborts cleanly; the next full frame after the line idles is received correctly.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: 8E1/8O1 frame (per PARITY_ODD); PARITY state present; parity_err = XOR(data, parity bit)
//    mismatch vs PARITY_ODD.
//  Not defined: 8N1 only; PARITY state absent; parity_err constant 0.
// STRUCTURE
//  uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), OVERSAMPLE=16, MID_SAMPLE=7,
//    LAST_SAMPLE=15, DATA_BITS=8.
//  Sub-module uart_baud_tick (clk, reset, baud_div -> tick); shared with the transmit side.
// TESTING  (clk 50 ns; baud_div=129 -> 9600 baud, bit = 2080 clk = 104 us)
//  1 Idle line 1 ms after reset -> rx_valid=0, all flags 0, rx_data=0x00.
//  2 Frame 0x69 (start, 1,0,0,1,0,1,1,0, stop=1) -> rx_data=0x69, rx_valid=1, frame_err=0 ~990 us after start edge;
//    rx_ack 1 clk -> rx_valid=0.
//  3 Low pulse of 400 clk (~3 ticks) on idle line -> no rx_valid, FSM back in IDLE; following 0x83 frame -> 0x83.
//  4 Frame 0xA5 with stop bit 0, line held low 3 bit times -> rx_data=0xA5, frame_err=1; no extra frame;
//    next 0x3C after line high -> 0x3C, frame_err=0.
//  5 Frames 0x11 then 0x22 without rx_ack -> rx_data=0x11, overrun=1; rx_ack -> overrun=0, rx_valid=0;
//    rx_ack on the deliver clock of 0x22 -> rx_data=0x22, rx_valid=1, overrun=0.
//  6 reset=0 for 3 clk during DATA bit 4 of 0x55 -> all outputs 0; next 0xC3 -> 0xC3.
//    With UART_RX_PARITY_EN, PARITY_ODD=0: 0x69 + parity 1 -> parity_err=1; 0x69 + parity 0 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, oversampling constants
// and the parity helper used by the receive frame logic.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int LAST_SAMPLE = 15;
    localparam int DATA_BITS   = 8;

    // High when data plus received parity bit disagree with the configured sense.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic                 par_bit,
                                             input logic                 odd);
        return (^data) ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every baud_div+1 clocks.
// A new divisor is picked up at the reload so a period never gets cut short.
module uart_baud_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_q;

    assign tick = (count == div_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            div_q <= '0;
        end else if (tick) begin
            count <= '0;
            div_q <= baud_div;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front-end: synchronises rx_in, finds start bits with 16x oversampling
// and deserialises LSB-first frames. Define UART_RX_PARITY_EN for 8E1/8O1 frames.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rx_ack,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS);
    localparam logic [SCNT_W-1:0] MID_CNT  = SCNT_W'(MID_SAMPLE);
    localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(LAST_SAMPLE);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_m;
    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [SCNT_W-1:0]    scnt;
    logic [SCNT_W-1:0]    scnt_nxt;
    logic [BCNT_W-1:0]    bcnt;
    logic [BCNT_W-1:0]    bcnt_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 stop_bit;
    logic                 stop_nxt;
    logic                 dlv;
    logic                 dlv_nxt;
    logic                 par_bit;
    logic                 accept;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .baud_div(baud_div),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_bit <= 1'b0;
        else        par_bit <= par_nxt;
    end
`else
    // No parity bit on the line: a value that always matches keeps parity_err at 0.
    assign par_bit = (^shreg) ^ 1'(PARITY_ODD);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            scnt     <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            stop_bit <= 1'b0;
            dlv      <= 1'b0;
        end else begin
            state    <= state_nxt;
            scnt     <= scnt_nxt;
            bcnt     <= bcnt_nxt;
            shreg    <= shreg_nxt;
            stop_bit <= stop_nxt;
            dlv      <= dlv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        stop_nxt  = stop_bit;
        dlv_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
`endif
        if (tick) begin
            scnt_nxt = scnt + SCNT_W'(1);
            case (state)
                ST_IDLE: begin
                    scnt_nxt = '0;
                    if (!rx_s) state_nxt = ST_START;
                end
                ST_START: begin
                    if (scnt == MID_CNT) begin
                        scnt_nxt = '0;
                        bcnt_nxt = '0;
                        if (rx_s) state_nxt = ST_IDLE;
                        else      state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Line order is LSB first, so each bit enters at the top.
                    if (scnt == LAST_CNT) begin
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        bcnt_nxt  = bcnt + BCNT_W'(1);
                        if (bcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (scnt == LAST_CNT) begin
                        par_nxt   = rx_s;
                        state_nxt = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (scnt == LAST_CNT) begin
                        stop_nxt = rx_s;
                        dlv_nxt  = 1'b1;
                        if (rx_s) state_nxt = ST_IDLE;
                        else      state_nxt = ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    scnt_nxt = '0;
                    if (rx_s) state_nxt = ST_IDLE;
                end
                default: begin
                    scnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // A simultaneous ack frees the holding register, so the new byte wins.
    assign accept = dlv && (!rx_valid || rx_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (accept) begin
            rx_data    <= shreg;
            frame_err  <= !stop_bit;
            parity_err <= parity_mismatch(shreg, par_bit, 1'(PARITY_ODD));
            rx_valid   <= 1'b1;
            overrun    <= 1'b0;
        end else if (dlv) begin
            overrun <= 1'b1;
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
